// File: rtl/mem_stream_scheduler.sv
// Sequences activation/filter streaming requests from MEM and compute phases on the PE
// across conv layers and K' filter groups. Protocol violations raise a sticky error.
module mem_stream_scheduler #(
   parameter int NUM_LAYERS = 4,
   parameter int MAX_K      = 8,
   parameter int CNT_W      = 32
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic [$clog2(NUM_LAYERS+1)-1:0]        num_layers,
   input  logic [NUM_LAYERS*$clog2(MAX_K+1)-1:0]  num_k,
   input  logic                                   stream_input_finish,
   input  logic                                   stream_filter_finish,
   input  logic                                   pe_done,
   output logic                                   req_stream_input_valid,
   output logic                                   req_stream_filter_valid,
   output logic [$clog2(NUM_LAYERS)-1:0]          current_conv_layer,
   output logic [$clog2(MAX_K)-1:0]               current_k,
   output logic                                   busy,
   output logic                                   layer_done,
   output logic                                   all_done,
   output logic                                   error,
   output logic [CNT_W-1:0]                       run_cycles
);

   localparam int LW  = $clog2(NUM_LAYERS+1);
   localparam int KW  = $clog2(MAX_K+1);
   localparam int LIW = $clog2(NUM_LAYERS);
   localparam int KIW = $clog2(MAX_K);

   typedef enum logic [2:0] {
      IDLE, REQ_INPUT, WAIT_INPUT, WAIT_FILTER, REQ_FILTER, COMPUTE, ADVANCE, DONE
   } state_t;

   state_t                      state_q;
   logic [LW-1:0]               nl_q;
   logic [NUM_LAYERS*KW-1:0]    nk_q;
   logic [LIW-1:0]              layer_q;
   logic [KIW-1:0]              k_q;
   logic                        req_in_q, req_f_q, busy_q, layer_done_q, all_done_q, error_q;
   logic [CNT_W-1:0]            run_q, run_d;
   logic                        cfg_bad, stray;
   logic [KW-1:0]               nk_cur;

   always_comb begin
      cfg_bad = (num_layers == '0) || (int'(num_layers) > NUM_LAYERS);
      for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
         if (i < 32'(num_layers) &&
             ((num_k[i*KW +: KW] == '0) || (int'(num_k[i*KW +: KW]) > MAX_K)))
            cfg_bad = 1'b1;
      end
   end

   // Filter finish is legal in WAIT_INPUT only when it lands together with input finish.
   always_comb begin
      stray = (stream_input_finish  && (state_q != WAIT_INPUT)) ||
              (stream_filter_finish && !((state_q == WAIT_FILTER) ||
                                         ((state_q == WAIT_INPUT) && stream_input_finish))) ||
              (pe_done && (state_q != COMPUTE));
   end

   always_comb begin
      run_d = run_q;
      if (busy_q && (run_q != '1))
         run_d = run_q + CNT_W'(1);
   end

   assign nk_cur = nk_q[layer_q*KW +: KW];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         nl_q         <= '0;
         nk_q         <= '0;
         layer_q      <= '0;
         k_q          <= '0;
         req_in_q     <= 1'b0;
         req_f_q      <= 1'b0;
         busy_q       <= 1'b0;
         layer_done_q <= 1'b0;
         all_done_q   <= 1'b0;
         error_q      <= 1'b0;
         run_q        <= '0;
      end else begin
         req_in_q     <= 1'b0;
         req_f_q      <= 1'b0;
         layer_done_q <= 1'b0;
         run_q        <= run_d;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (cfg_bad) begin
                     error_q <= 1'b1;
                  end else begin
                     nl_q       <= num_layers;
                     nk_q       <= num_k;
                     layer_q    <= '0;
                     k_q        <= '0;
                     all_done_q <= 1'b0;
                     error_q    <= 1'b0;
                     run_q      <= '0;
                     busy_q     <= 1'b1;
                     state_q    <= REQ_INPUT;
                  end
               end
            end
            REQ_INPUT: begin
               req_in_q <= 1'b1;
               state_q  <= WAIT_INPUT;
            end
            WAIT_INPUT: begin
               if (stream_input_finish && stream_filter_finish) state_q <= COMPUTE;
               else if (stream_input_finish)                    state_q <= WAIT_FILTER;
            end
            REQ_FILTER: begin
               req_f_q <= 1'b1;
               state_q <= WAIT_FILTER;
            end
            WAIT_FILTER: if (stream_filter_finish) state_q <= COMPUTE;
            COMPUTE:     if (pe_done)              state_q <= ADVANCE;
            ADVANCE: begin
               if ((KW'(k_q) + KW'(1)) < nk_cur) begin
                  k_q     <= k_q + KIW'(1);
                  state_q <= REQ_FILTER;
               end else if ((LW'(layer_q) + LW'(1)) < nl_q) begin
                  layer_done_q <= 1'b1;
                  k_q          <= '0;
                  layer_q      <= layer_q + LIW'(1);
                  state_q      <= REQ_FILTER;
               end else begin
                  layer_done_q <= 1'b1;
                  all_done_q   <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= DONE;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         if (stray) error_q <= 1'b1;
      end
   end

   assign req_stream_input_valid  = req_in_q;
   assign req_stream_filter_valid = req_f_q;
   assign current_conv_layer      = layer_q;
   assign current_k               = k_q;
   assign busy                    = busy_q;
   assign layer_done              = layer_done_q;
   assign all_done                = all_done_q;
   assign error                   = error_q;
   assign run_cycles              = run_q;

endmodule

// File: tb/tb_mem_stream_scheduler.sv
// Directed bench for mem_stream_scheduler; a second instance with a 4-bit counter
// shares the stimulus to exercise run_cycles saturation.
module tb_mem_stream_scheduler;

   logic        clk = 1'b0;
   logic        rst, start, sif, sff, pe;
   logic [2:0]  num_layers;
   logic [15:0] num_k;

   logic        req_in, req_f, busy, ldone, adone, err;
   logic [1:0]  layer;
   logic [2:0]  kidx;
   logic [31:0] runc;

   logic        req_in2, req_f2, busy2, ldone2, adone2, err2;
   logic [1:0]  layer2;
   logic [2:0]  kidx2;
   logic [3:0]  runc2;

   int total = 0;
   int bad   = 0;
   int n_in = 0, n_f = 0, n_ld = 0;
   int s_in, s_f, s_ld;

   always #5 clk = ~clk;

   mem_stream_scheduler #(.NUM_LAYERS(4), .MAX_K(8), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .num_layers(num_layers), .num_k(num_k),
      .stream_input_finish(sif), .stream_filter_finish(sff), .pe_done(pe),
      .req_stream_input_valid(req_in), .req_stream_filter_valid(req_f),
      .current_conv_layer(layer), .current_k(kidx), .busy(busy), .layer_done(ldone),
      .all_done(adone), .error(err), .run_cycles(runc));

   mem_stream_scheduler #(.NUM_LAYERS(4), .MAX_K(8), .CNT_W(4)) dut_sat (
      .clk(clk), .rst(rst), .start(start), .num_layers(num_layers), .num_k(num_k),
      .stream_input_finish(sif), .stream_filter_finish(sff), .pe_done(pe),
      .req_stream_input_valid(req_in2), .req_stream_filter_valid(req_f2),
      .current_conv_layer(layer2), .current_k(kidx2), .busy(busy2), .layer_done(ldone2),
      .all_done(adone2), .error(err2), .run_cycles(runc2));

   always @(negedge clk) begin
      if (req_in) n_in++;
      if (req_f)  n_f++;
      if (ldone)  n_ld++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1; tick(); start = 1'b0;
   endtask
   task automatic pulse_sif();
      sif = 1'b1; tick(); sif = 1'b0;
   endtask
   task automatic pulse_sff();
      sff = 1'b1; tick(); sff = 1'b0;
   endtask
   task automatic pulse_pe();
      pe = 1'b1; tick(); pe = 1'b0;
   endtask

   // Entered with the DUT in REQ_FILTER; leaves it just after ADVANCE has executed.
   task automatic filter_group(input string tag, input int el, input int ek);
      tick();
      chk({tag, "_freq"},  32'(req_f), 1);
      chk({tag, "_layer"}, 32'(layer), 32'(el));
      chk({tag, "_k"},     32'(kidx),  32'(ek));
      pulse_sff();
      pulse_pe();
      tick();
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; sif = 1'b0; sff = 1'b0; pe = 1'b0;
      num_layers = 3'd1; num_k = 16'h1111;
      tick(); tick();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_adone", 32'(adone), 0);
      chk("rst_err", 32'(err), 0);
      chk("rst_run", runc, 0);
      rst = 1'b1;
      tick();
      chk("post_rst_reqin", 32'(req_in), 0);

      // single layer, single group
      s_f = n_f;
      pulse_start();
      chk("t1_busy", 32'(busy), 1);
      chk("t1_reqin_early", 32'(req_in), 0);
      tick();
      chk("t1_reqin", 32'(req_in), 1);
      chk("t1_layer", 32'(layer), 0);
      chk("t1_k", 32'(kidx), 0);
      tick();
      chk("t1_reqin_one", 32'(req_in), 0);
      pulse_sif();
      pulse_sff();
      pulse_pe();
      chk("t1_no_ldone_yet", 32'(ldone), 0);
      tick();
      chk("t1_ldone", 32'(ldone), 1);
      chk("t1_adone", 32'(adone), 1);
      chk("t1_busy_done", 32'(busy), 0);
      chk("t1_run", runc, 6);
      chk("t1_err", 32'(err), 0);
      tick();
      chk("t1_ldone_pulse", 32'(ldone), 0);
      chk("t1_adone_hold", 32'(adone), 1);
      chk("t1_nofreq", 32'(n_f - s_f), 0);

      // two layers, K' = {3,2}
      num_layers = 3'd2; num_k = 16'h1123;
      s_in = n_in; s_f = n_f; s_ld = n_ld;
      pulse_start();
      chk("t2_adone_clr", 32'(adone), 0);
      tick();
      chk("t2_reqin", 32'(req_in), 1);
      pulse_sif();
      pulse_sff();
      chk("t2_l0k0_layer", 32'(layer), 0);
      chk("t2_l0k0_k", 32'(kidx), 0);
      pulse_pe();
      tick();
      filter_group("t2_l0k1", 0, 1);
      filter_group("t2_l0k2", 0, 2);
      chk("t2_ldone0", 32'(ldone), 1);
      filter_group("t2_l1k0", 1, 0);
      filter_group("t2_l1k1", 1, 1);
      chk("t2_ldone1", 32'(ldone), 1);
      chk("t2_adone", 32'(adone), 1);
      tick();
      chk("t2_nin", 32'(n_in - s_in), 1);
      chk("t2_nf", 32'(n_f - s_f), 4);
      chk("t2_nld", 32'(n_ld - s_ld), 2);
      chk("t2_err", 32'(err), 0);

      // ignored start while busy, joint finishes, stray filter finish in COMPUTE
      num_layers = 3'd1; num_k = 16'h1111;
      pulse_start();
      tick();
      pulse_start();
      chk("t3_start_ignored_reqin", 32'(req_in), 0);
      chk("t3_start_ignored_err", 32'(err), 0);
      sif = 1'b1; sff = 1'b1; tick(); sif = 1'b0; sff = 1'b0;
      chk("t3_joint_err", 32'(err), 0);
      pulse_sff();
      chk("t3_stray_err", 32'(err), 1);
      chk("t3_stray_busy", 32'(busy), 1);
      pulse_pe();
      tick();
      chk("t3_adone", 32'(adone), 1);
      chk("t3_err_sticky", 32'(err), 1);
      tick();

      // reset in WAIT_FILTER of layer 1
      num_layers = 3'd2; num_k = 16'h1111;
      pulse_start();
      chk("t4_err_clr", 32'(err), 0);
      tick();
      pulse_sif();
      pulse_sff();
      pulse_pe();
      tick();
      tick();
      chk("t4_freq_l1", 32'(req_f), 1);
      chk("t4_layer_l1", 32'(layer), 1);
      rst = 1'b0;
      tick();
      chk("t4_rst_busy", 32'(busy), 0);
      chk("t4_rst_layer", 32'(layer), 0);
      chk("t4_rst_freq", 32'(req_f), 0);
      chk("t4_rst_run", runc, 0);
      rst = 1'b1;
      tick();
      chk("t4_rel_reqin", 32'(req_in), 0);
      chk("t4_rel_freq", 32'(req_f), 0);
      num_layers = 3'd1;
      pulse_start();
      tick();
      chk("t4_replay_reqin", 32'(req_in), 1);
      chk("t4_replay_layer", 32'(layer), 0);
      pulse_sif();
      pulse_sff();
      pulse_pe();
      tick();
      chk("t4_replay_adone", 32'(adone), 1);
      tick();

      // counter saturation on the narrow instance, then bad configuration
      pulse_start();
      repeat (20) tick();
      chk("t5_run_wide", runc, 20);
      chk("t5_run_sat", 32'(runc2), 15);
      pulse_sif();
      pulse_sff();
      pulse_pe();
      tick();
      chk("t5_run_wide_end", runc, 24);
      chk("t5_run_sat_end", 32'(runc2), 15);
      tick(); tick();
      chk("t5_run_hold", runc, 24);
      num_k = 16'h1110;
      pulse_start();
      chk("t5_badk_err", 32'(err), 1);
      chk("t5_badk_busy", 32'(busy), 0);
      tick();
      chk("t5_badk_reqin", 32'(req_in), 0);
      chk("t5_badk_busy2", 32'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
